// File: rtl/serial_adder_if.sv
// ============================================================================
// serial_adder_if : start/busy/done handshake and operand/result bundle
// Revision: 1.0
// ============================================================================
`default_nettype none

interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout, ovf
    );
endinterface

`default_nettype wire

// File: rtl/serial_adder.sv
// ============================================================================
// serial_adder : bit-serial WIDTH-bit adder, LSB first, one bit per clock
// Revision: 1.0
// ============================================================================
`default_nettype none

module serial_adder #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    serial_adder_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic [WIDTH-1:0] r_s_sr;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;

    logic             w_s;
    logic             w_c_next;
    logic             w_last;

    // Single full-adder cell operating on the current LSBs and the carry flop
    assign w_s      = r_a_sr[0] ^ r_b_sr[0] ^ r_carry;
    assign w_c_next = (r_a_sr[0] & r_b_sr[0]) | (r_carry & (r_a_sr[0] ^ r_b_sr[0]));
    assign w_last   = (r_cnt == c_LAST_BIT);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_a_sr  <= '0;
            r_b_sr  <= '0;
            r_s_sr  <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                // DONE accepts a new start exactly like IDLE (back-to-back mode)
                ST_IDLE, ST_DONE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_a_sr  <= bus.a;
                        r_b_sr  <= bus.b;
                        r_s_sr  <= '0;
                        r_carry <= bus.cin;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ST_RUN;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    r_a_sr  <= r_a_sr >> 1;
                    r_b_sr  <= r_b_sr >> 1;
                    r_s_sr  <= {w_s, r_s_sr[WIDTH-1:1]};
                    r_carry <= w_c_next;
                    if (w_last) begin
                        // r_carry here is the carry into the MSB
                        r_sum   <= {w_s, r_s_sr[WIDTH-1:1]};
                        r_cout  <= w_c_next;
                        r_ovf   <= r_carry ^ w_c_next;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.sum  = r_sum;
    assign bus.cout = r_cout;
    assign bus.ovf  = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_serial_adder.sv
// ============================================================================
// tb_serial_adder : directed bench for serial_adder at WIDTH = 8, 2 and 16
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_serial_adder;

    logic clk;
    logic rst_n;
    bit   chk_en;
    int   checks;
    int   errors;

    serial_adder_if #(.WIDTH(8))  if8  ();
    serial_adder_if #(.WIDTH(2))  if2  ();
    serial_adder_if #(.WIDTH(16)) if16 ();

    serial_adder #(.WIDTH(8))  u_dut8  (.clk(clk), .rst_n(rst_n), .bus(if8.slave));
    serial_adder #(.WIDTH(2))  u_dut2  (.clk(clk), .rst_n(rst_n), .bus(if2.slave));
    serial_adder #(.WIDTH(16)) u_dut16 (.clk(clk), .rst_n(rst_n), .bus(if16.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Transaction-level reference: result from integer arithmetic, timing from latency rule
    typedef struct {
        bit     busy;
        bit     done;
        longint sum;
        bit     cout;
        bit     ovf;
        int     left;
        longint psum;
        bit     pcout;
        bit     povf;
    } mdl_t;

    mdl_t m8, m2, m16;

    function automatic mdl_t mstep(mdl_t m, int w, bit rstn, bit st,
                                   longint a, longint b, bit cin);
        mdl_t   n;
        longint tot, half, sa, sb, ss;
        n = m;
        if (!rstn) begin
            n = '{default: 0};
            return n;
        end
        if (m.busy) begin
            n.left = m.left - 1;
            if (n.left == 0) begin
                n.busy = 1'b0;
                n.done = 1'b1;
                n.sum  = m.psum;
                n.cout = m.pcout;
                n.ovf  = m.povf;
            end
        end else begin
            n.done = 1'b0;
            if (st) begin
                half    = longint'(1) << (w - 1);
                tot     = a + b + longint'(cin);
                n.busy  = 1'b1;
                n.left  = w;
                n.psum  = tot % (2 * half);
                n.pcout = (tot >= 2 * half);
                sa      = (a >= half) ? a - 2 * half : a;
                sb      = (b >= half) ? b - 2 * half : b;
                ss      = sa + sb + longint'(cin);
                n.povf  = (ss >= half) || (ss < -half);
            end
        end
        return n;
    endfunction

    always @(posedge clk) begin
        m8  <= mstep(m8,  8,  rst_n, if8.start,  longint'(if8.a),  longint'(if8.b),  if8.cin);
        m2  <= mstep(m2,  2,  rst_n, if2.start,  longint'(if2.a),  longint'(if2.b),  if2.cin);
        m16 <= mstep(m16, 16, rst_n, if16.start, longint'(if16.a), longint'(if16.b), if16.cin);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("w8 busy",  if8.busy,  m8.busy);
            chk("w8 done",  if8.done,  m8.done);
            chk("w8 sum",   if8.sum,   m8.sum);
            chk("w8 cout",  if8.cout,  m8.cout);
            chk("w8 ovf",   if8.ovf,   m8.ovf);
            chk("w2 busy",  if2.busy,  m2.busy);
            chk("w2 done",  if2.done,  m2.done);
            chk("w2 sum",   if2.sum,   m2.sum);
            chk("w2 cout",  if2.cout,  m2.cout);
            chk("w2 ovf",   if2.ovf,   m2.ovf);
            chk("w16 busy", if16.busy, m16.busy);
            chk("w16 done", if16.done, m16.done);
            chk("w16 sum",  if16.sum,  m16.sum);
            chk("w16 cout", if16.cout, m16.cout);
            chk("w16 ovf",  if16.ovf,  m16.ovf);
        end
    end

    task automatic drive(input int sel, input bit st, input longint a, input longint b, input bit cin);
        case (sel)
            2: begin
                if2.start = st; if2.a = a[1:0]; if2.b = b[1:0]; if2.cin = cin;
            end
            16: begin
                if16.start = st; if16.a = a[15:0]; if16.b = b[15:0]; if16.cin = cin;
            end
            default: begin
                if8.start = st; if8.a = a[7:0]; if8.b = b[7:0]; if8.cin = cin;
            end
        endcase
    endtask

    function automatic logic get_done(input int sel);
        case (sel)
            2:       return if2.done;
            16:      return if16.done;
            default: return if8.done;
        endcase
    endfunction

    function automatic logic get_busy(input int sel);
        case (sel)
            2:       return if2.busy;
            16:      return if16.busy;
            default: return if8.busy;
        endcase
    endfunction

    // Start is high across exactly one rising edge (edge k)
    task automatic start_op(input int sel, input longint a, input longint b, input bit cin);
        @(posedge clk); #1;
        drive(sel, 1'b1, a, b, cin);
        @(posedge clk); #1;
        drive(sel, 1'b0, a, b, cin);
    endtask

    // Returns busy-high negedges seen and total negedges up to and including done
    task automatic wait_done(input int sel, input int budget, output int nbusy, output int cycles);
        bit ok;
        ok     = 1'b0;
        nbusy  = 0;
        cycles = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            cycles++;
            if (get_done(sel)) begin
                ok = 1'b1;
                break;
            end
            if (get_busy(sel)) nbusy++;
        end
        chk("done timeout", 64'(ok), 64'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int nb, cy, extra;
        longint tot, sa, sb, ss;
        checks = 0;
        errors = 0;
        chk_en = 1'b0;
        rst_n  = 1'b0;
        drive(8, 0, 0, 0, 0);
        drive(2, 0, 0, 0, 0);
        drive(16, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        chk_en = 1'b1;
        @(negedge clk);
        chk("reset busy", if8.busy, 64'd0);
        chk("reset done", if8.done, 64'd0);
        chk("reset sum",  if8.sum,  64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // 0x5A + 0x33: unsigned 0x8D, signed 90+51 overflows
        start_op(8, 'h5A, 'h33, 0);
        wait_done(8, 40, nb, cy);
        chk("t1 busy cycles", 64'(nb), 64'd8);
        chk("t1 done edge",   64'(cy), 64'd9);
        chk("t1 sum",  if8.sum,  64'h8D);
        chk("t1 cout", if8.cout, 64'd0);
        chk("t1 ovf",  if8.ovf,  64'd1);

        // Back-to-back: second start presented during the DONE cycle
        start_op(8, 'hFF, 'h01, 0);
        wait_done(8, 40, nb, cy);
        chk("t2a sum",  if8.sum,  64'h00);
        chk("t2a cout", if8.cout, 64'd1);
        chk("t2a ovf",  if8.ovf,  64'd0);
        drive(8, 1, 'h80, 'h80, 1);
        @(posedge clk); #1;
        drive(8, 0, 'h80, 'h80, 1);
        wait_done(8, 40, nb, cy);
        chk("t2 b2b gap", 64'(cy), 64'd9);
        chk("t2b sum",  if8.sum,  64'h01);
        chk("t2b cout", if8.cout, 64'd1);
        chk("t2b ovf",  if8.ovf,  64'd1);

        // Start and operand activity while busy must be ignored
        start_op(8, 'h10, 'h20, 0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            drive(8, bit'(i % 2 == 0), longint'(8'hA5 ^ i), 'h5C, 1);
        end
        drive(8, 0, 'h00, 'h00, 0);
        wait_done(8, 40, nb, cy);
        chk("t3 sum",  if8.sum,  64'h30);
        chk("t3 cout", if8.cout, 64'd0);
        extra = 0;
        repeat (12) begin
            @(negedge clk);
            if (if8.done) extra++;
        end
        chk("t3 extra done", 64'(extra), 64'd0);

        // Reset in the middle of RUN discards the operation
        start_op(8, 'h7F, 'h7F, 1);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("t4 busy", if8.busy, 64'd0);
        chk("t4 sum",  if8.sum,  64'd0);
        chk("t4 cout", if8.cout, 64'd0);
        chk("t4 ovf",  if8.ovf,  64'd0);
        extra = 0;
        repeat (12) begin
            @(negedge clk);
            if (if8.done) extra++;
        end
        chk("t4 no done", 64'(extra), 64'd0);
        start_op(8, 'h01, 'h01, 0);
        wait_done(8, 40, nb, cy);
        chk("t4 sum after", if8.sum, 64'h02);

        // WIDTH=2 exhaustive sweep
        for (int a = 0; a < 4; a++) begin
            for (int b = 0; b < 4; b++) begin
                for (int c = 0; c < 2; c++) begin
                    start_op(2, longint'(a), longint'(b), bit'(c));
                    wait_done(2, 20, nb, cy);
                    tot = longint'(a + b + c);
                    sa  = (a >= 2) ? longint'(a - 4) : longint'(a);
                    sb  = (b >= 2) ? longint'(b - 4) : longint'(b);
                    ss  = sa + sb + longint'(c);
                    chk("w2x sum",  if2.sum,  64'(tot % 4));
                    chk("w2x cout", if2.cout, 64'(tot / 4));
                    chk("w2x ovf",  if2.ovf,  64'((ss > 1) || (ss < -2)));
                    chk("w2x busy cycles", 64'(nb), 64'd2);
                end
            end
        end

        // WIDTH=16 all-ones corner
        start_op(16, 'hFFFF, 'hFFFF, 1);
        wait_done(16, 60, nb, cy);
        chk("t6 busy cycles", 64'(nb), 64'd16);
        chk("t6 done edge",   64'(cy), 64'd17);
        chk("t6 sum",  if16.sum,  64'hFFFF);
        chk("t6 cout", if16.cout, 64'd1);
        chk("t6 ovf",  if16.ovf,  64'd0);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
